// File: rtl/proc_run_ctrl_pkg.sv
// proc_run_ctrl_pkg: shared state/halt-cause encodings and default widths for the run controller.
package proc_run_ctrl_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int PC_W_DEF  = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;
  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_STOP  = 3'd1,
    CAUSE_LIMIT = 3'd2,
    CAUSE_BP    = 3'd3,
    CAUSE_STEP  = 3'd4
  } cause_t;
endpackage

// File: rtl/proc_run_ctrl_edge_det.sv
// run_edge_det: registered rising-edge detector for operator command inputs.
module run_edge_det (
  input  logic clk,
  input  logic Proc_reset,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or posedge Proc_reset)
    if (Proc_reset) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/step/halt sequencer generating the PC advance enable.
// Optional PC breakpoint enabled by defining RUN_CTRL_BREAKPOINT_EN.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic             clk,
  input  logic             Proc_reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  output logic             Proc_run_en,
  output logic [1:0]       state_o,
  output logic [2:0]       halt_cause_o,
  output logic [CNT_W-1:0] adv_cnt_o
);
  state_t state;
  cause_t cause;
  logic start_rise, step_rise, limit_hit, bp_hit, halt_now;
  run_edge_det u_start (.clk(clk), .Proc_reset(Proc_reset), .d(start_i), .rise(start_rise));
  run_edge_det u_step  (.clk(clk), .Proc_reset(Proc_reset), .d(step_i),  .rise(step_rise));
  assign limit_hit = (limit_i != '0) && (adv_cnt_o >= limit_i);
`ifdef RUN_CTRL_BREAKPOINT_EN
  // resume masks the breakpoint for the first RUN cycle so a restart at bp_addr moves on
  logic resume;
  assign bp_hit = bp_en_i && (pc_i == bp_addr_i) && !resume;
  always_ff @(posedge clk or posedge Proc_reset)
    if (Proc_reset) resume <= 1'b0;
    else if ((state == ST_IDLE || state == ST_HALT) && start_rise) resume <= 1'b1;
    else if (state == ST_RUN) resume <= 1'b0;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_i, bp_addr_i};
  assign bp_hit = 1'b0;
`endif
  assign halt_now = stop_i | limit_hit | bp_hit;
  assign Proc_run_en = (state == ST_RUN && !halt_now) || (state == ST_STEP && !limit_hit);
  always_ff @(posedge clk or posedge Proc_reset)
    if (Proc_reset) begin
      state <= ST_IDLE;
      cause <= CAUSE_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_HALT:
          if (start_rise) begin
            state <= ST_RUN;
            cause <= CAUSE_NONE;
          end else if (step_rise) begin
            state <= ST_STEP;
            cause <= CAUSE_NONE;
          end
        ST_RUN:
          if (halt_now) begin
            state <= ST_HALT;
            cause <= stop_i ? CAUSE_STOP : limit_hit ? CAUSE_LIMIT : CAUSE_BP;
          end
        ST_STEP: begin
          state <= ST_HALT;
          cause <= limit_hit ? CAUSE_LIMIT : CAUSE_STEP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge Proc_reset)
    if (Proc_reset) adv_cnt_o <= '0;
    else if (Proc_run_en && adv_cnt_o != '1) adv_cnt_o <= adv_cnt_o + 1'b1;
  assign state_o      = state;
  assign halt_cause_o = cause;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed self-checking bench for proc_run_ctrl.
module tb_proc_run_ctrl;
  logic        clk = 1'b0;
  logic        Proc_reset = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, step_i = 1'b0;
  logic [31:0] pc, limit_i = '0, bp_addr_i = '0;
  logic        bp_en_i = 1'b0;
  logic        Proc_run_en;
  logic [1:0]  state_o;
  logic [2:0]  halt_cause_o;
  logic [31:0] adv_cnt_o;
  int          compared = 0, mismatched = 0, adv;
  proc_run_ctrl dut (
    .clk(clk), .Proc_reset(Proc_reset), .start_i(start_i), .stop_i(stop_i), .step_i(step_i),
    .pc_i(pc), .limit_i(limit_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i),
    .Proc_run_en(Proc_run_en), .state_o(state_o), .halt_cause_o(halt_cause_o), .adv_cnt_o(adv_cnt_o)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge Proc_reset)
    if (Proc_reset) pc <= '0;
    else if (Proc_run_en) pc <= pc + 32'd4;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  initial begin
    #3;
    check("rst_state", state_o, 0);
    check("rst_cause", halt_cause_o, 0);
    check("rst_cnt", adv_cnt_o, 0);
    check("rst_run_en", Proc_run_en, 0);
    tick();
    Proc_reset = 1'b0;
    // continuous run, unlimited
    pulse_start();
    check("run_state", state_o, 1);
    adv = 0;
    for (int i = 0; i < 10; i++) begin
      adv += Proc_run_en;
      tick();
    end
    check("run_adv10", adv, 10);
    check("run_cnt10", adv_cnt_o, 10);
    check("run_state_after", state_o, 1);
    // asynchronous reset between edges
    Proc_reset = 1'b1;
    #2;
    check("arst_state", state_o, 0);
    check("arst_cnt", adv_cnt_o, 0);
    check("arst_run_en", Proc_run_en, 0);
    #2;
    Proc_reset = 1'b0;
    tick();
    check("arst_idle", state_o, 0);
    // limit of 5 advances
    limit_i = 32'd5;
    pulse_start();
    adv = 0;
    for (int i = 0; i < 8; i++) begin
      adv += Proc_run_en;
      tick();
    end
    check("lim_adv", adv, 5);
    check("lim_cnt", adv_cnt_o, 5);
    check("lim_state", state_o, 3);
    check("lim_cause", halt_cause_o, 2);
    pulse_start();
    check("lim_restart_state", state_o, 1);
    check("lim_restart_en", Proc_run_en, 0);
    tick();
    check("lim_restart_halt", state_o, 3);
    check("lim_restart_cause", halt_cause_o, 2);
    check("lim_restart_cnt", adv_cnt_o, 5);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    check("lim_step_en", Proc_run_en, 0);
    tick();
    check("lim_step_cause", halt_cause_o, 2);
    check("lim_step_cnt", adv_cnt_o, 5);
    // single steps
    limit_i = '0;
    for (int i = 0; i < 3; i++) begin
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      check("step_state", state_o, 2);
      check("step_cause_clr", halt_cause_o, 0);
      check("step_en", Proc_run_en, 1);
      tick();
      check("step_halt", state_o, 3);
      check("step_cause", halt_cause_o, 4);
    end
    check("step_cnt", adv_cnt_o, 8);
    step_i = 1'b1;
    adv = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 5) step_i = 1'b0;
      adv += Proc_run_en;
    end
    check("step_held_adv", adv, 1);
    check("step_held_cnt", adv_cnt_o, 9);
    // stop coinciding with limit and breakpoint; start beats step, stop ignored in HALT
    limit_i = 32'd11;
    bp_en_i = 1'b1;
    bp_addr_i = pc + 32'd8;
    stop_i = 1'b1;
    tick();
    check("halt_stop_ignored", state_o, 3);
    stop_i = 1'b0;
    start_i = 1'b1;
    step_i = 1'b1;
    tick();
    start_i = 1'b0;
    step_i = 1'b0;
    check("start_beats_step", state_o, 1);
    tick();
    tick();
    check("coinc_cnt", adv_cnt_o, 11);
    stop_i = 1'b1;
    check("coinc_en", Proc_run_en, 0);
    tick();
    stop_i = 1'b0;
    check("coinc_state", state_o, 3);
    check("coinc_cause", halt_cause_o, 1);
    check("coinc_cnt_hold", adv_cnt_o, 11);
    // breakpoint at 0x10 with PC stepping by 4
    Proc_reset = 1'b1;
    tick();
    Proc_reset = 1'b0;
    limit_i = '0;
    bp_en_i = 1'b1;
    bp_addr_i = 32'h10;
    pulse_start();
`ifdef RUN_CTRL_BREAKPOINT_EN
    for (int i = 0; i < 10 && state_o != 2'd3; i++) tick();
    check("bp_state", state_o, 3);
    check("bp_cause", halt_cause_o, 3);
    check("bp_pc", pc, 32'h10);
    check("bp_cnt", adv_cnt_o, 4);
    pulse_start();
    check("bp_resume_en", Proc_run_en, 1);
    tick();
    check("bp_resume_pc", pc, 32'h14);
    tick();
    check("bp_resume_state", state_o, 1);
    check("bp_resume_pc2", pc, 32'h18);
`else
    for (int i = 0; i < 6; i++) tick();
    check("nobp_state", state_o, 1);
    check("nobp_cause", halt_cause_o, 0);
    check("nobp_pc", pc, 32'h18);
`endif
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("final_cause", halt_cause_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Run/step/halt sequencer for the processor's program counter. Generates the PC advance enable `Proc_run_en` from operator commands (start, stop, single-step).
- Halt sources: operator stop, an instruction-count limit, and an optional PC breakpoint.
- Sits between the board-level command inputs and the PC/datapath. Also reports run state, halt cause and the number of retired advances.

Parameters:
- CNT_W, 32, width of the advance counter and of the limit input.
- PC_W, 32, width of the PC observation and breakpoint address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- Proc_reset  in  1  asynchronous, active-high reset; same net that resets the PC.
- start_i  in  1  level/pulse; begin continuous run.
- stop_i  in  1  level/pulse; halt continuous run.
- step_i  in  1  level/pulse; advance exactly one instruction.
- pc_i  in  PC_W  current PC value (registered output of the PC).
- limit_i  in  CNT_W  advance limit; 0 = unlimited.
- bp_en_i  in  1  breakpoint enable (ignored without RUN_CTRL_BREAKPOINT_EN).
- bp_addr_i  in  PC_W  breakpoint address.
- Proc_run_en  out  1  PC advance enable; combinational from state and inputs.
- state_o  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALT.
- halt_cause_o  out  3  0 NONE, 1 STOP, 2 LIMIT, 3 BP, 4 STEP.
- adv_cnt_o  out  CNT_W  count of cycles with Proc_run_en=1.

Behaviour:
- Reset (async, Proc_reset=1): state=IDLE, halt_cause_o=0, adv_cnt_o=0, resume flag=0. Proc_run_en=0 while reset is asserted.
- Hit terms, evaluated every cycle:
  - limit_hit = (limit_i!=0) && (adv_cnt_o>=limit_i).
  - bp_hit = bp_en_i && pc_i==bp_addr_i && !resume.
  - halt_now = stop_i | limit_hit | bp_hit.
- Proc_run_en:
  - (state==RUN && !halt_now) || (state==STEP && !limit_hit).
  - The PC therefore never advances past a breakpoint, the limit, or a stop in the same cycle.
- IDLE/HALT:
  - start_i -> RUN; resume=1.
  - else step_i -> STEP.
  - start_i wins over step_i. stop_i in these states is ignored.
  - halt_cause_o holds its value until the next transition into HALT, and is cleared to 0 on entry to RUN or STEP.
- RUN:
  - If halt_now -> HALT, with halt_cause_o by priority STOP > LIMIT > BP.
  - resume clears after the first RUN cycle. This makes restarting from a PC equal to bp_addr advance once instead of re-halting.
- STEP:
  - Exactly one cycle. -> HALT with cause STEP, or LIMIT if limit_hit (no advance).
  - A step_i held high does not re-trigger until it has been seen low in IDLE/HALT (edge-qualified via a registered copy).
  - start_i is edge-qualified the same way.
- adv_cnt_o: increments by 1 on each posedge with Proc_run_en=1. Saturates at all-ones and does not wrap.
- Latency: start_i sampled at edge N puts the FSM in RUN; the first PC advance occurs at edge N+1.
- Reset mid-run: state returns to IDLE immediately and asynchronously; no partial advance.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- Defined: breakpoint comparator, resume flag and BP halt cause are present as described above.
- Undefined: bp_hit is constant 0 and the resume logic is removed. bp_en_i and bp_addr_i remain as ports but are unused; halt_cause_o never reports 3.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE/ST_RUN/ST_STEP/ST_HALT.
  - halt-cause constants CAUSE_NONE/STOP/LIMIT/BP/STEP.
  - the default widths.
- One natural sub-module: run_edge_det (registered rising-edge detector). Instantiate it twice, for start_i and step_i.

Test Plan:
- Reset then start pulse, limit=0, 10 cycles -> Proc_run_en=1 for 10 cycles; adv_cnt_o=10; state_o=1.
- Run with limit_i=5 -> exactly 5 advances; state_o=3, halt_cause_o=2; further start_i pulses yield 0 advances while adv_cnt_o>=5.
- Breakpoint (macro on), bp_addr=0x10, PC advancing by 4 from 0 -> halt with pc_i=0x10 and cause 3. A second start advances once to 0x14 and continues.
- Three step_i pulses from IDLE -> exactly 3 single-cycle advances, halt_cause_o=4 after each. step_i held high for 6 cycles -> only 1 advance.
- stop_i asserted in the same cycle as limit_hit and bp_hit -> halt_cause_o=1, no advance that cycle.
- Proc_reset asserted mid-run between clock edges -> state_o=0, adv_cnt_o=0, Proc_run_en=0 immediately, before the next edge.
